cache_read_adapter: RTL



---
 rtl/cache_read_adapter_pkg.sv | 29 ++
 rtl/cache_read_adapter_rsp_queue.sv | 65 ++++++
 rtl/cache_read_adapter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cache_read_adapter_pkg.sv
// Shared definitions for the cache read adapter and the cache FIFO scoreboard:
// response-entry layout {hit, tag, data} and the saturating counter helper.
package cache_read_adapter_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TAG_WIDTH  = 8;
    localparam int CNT_WIDTH      = 16;
    localparam int RESP_DATA_LSB  = 0;
    localparam int RESP_W         = DEF_TAG_WIDTH + DEF_DATA_WIDTH + 1;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    function automatic int resp_w(input int tag_w, input int data_w);
        return tag_w + data_w + 1;
    endfunction

    function automatic int resp_hit_bit(input int tag_w, input int data_w);
        return tag_w + data_w;
    endfunction

    function automatic int resp_tag_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/cache_read_adapter_rsp_queue.sv
// Synchronous response FIFO with extra-MSB pointers; flush empties it and
// takes priority over push and pop in the same cycle.
module cache_read_adapter_rsp_queue #(
    parameter int WIDTH      = 41,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  logic [WIDTH-1:0]    push_data_i,
    input  logic                pop_i,
    input  logic                flush_i,
    output logic [WIDTH-1:0]    head_o,
    output logic [ADDR_WIDTH:0] count_o,
    output logic                empty_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                full;
    logic                do_push;
    logic                do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the head slot this cycle, so push at full is legal alongside it.
    assign do_push = push_i && (!full || do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= push_data_i;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full && !pop_i));

endmodule

// File: rtl/cache_read_adapter.sv
// Read-side stage for the tagged cache FIFO: issues credit-gated lookups and
// queues the {tag, data, hit} responses that come back one cycle later.
module cache_read_adapter
    import cache_read_adapter_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int TAG_WIDTH     = 8,
    parameter int RQ_ADDR_WIDTH = 2,
    parameter bit GATE_ON_EMPTY = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    input  logic [TAG_WIDTH-1:0]    req_tag,
    output logic                    req_ready,
    output logic                    cf_rd_en,
    output logic [TAG_WIDTH-1:0]    cf_rd_tag,
    input  logic [DATA_WIDTH-1:0]   cf_rd_data,
    input  logic                    cf_rd_valid,
    input  logic                    cf_rd_hit,
    input  logic                    cf_empty,
    output logic                    resp_valid,
    output logic [TAG_WIDTH-1:0]    resp_tag,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    resp_hit,
    input  logic                    resp_ready,
    input  logic                    flush,
    output logic [RQ_ADDR_WIDTH:0]  rq_count,
    output logic [15:0]             hit_cnt,
    output logic [15:0]             miss_cnt,
    output logic                    proto_err
);

    localparam int RW      = resp_w(TAG_WIDTH, DATA_WIDTH);
    localparam int HIT_BIT = resp_hit_bit(TAG_WIDTH, DATA_WIDTH);
    localparam int TAG_LSB = resp_tag_lsb(DATA_WIDTH);
    localparam logic [RQ_ADDR_WIDTH:0] DEPTH_C = {1'b1, {RQ_ADDR_WIDTH{1'b0}}};

    logic                   inflight_q, inflight_d;
    logic                   drop_pending_q, drop_pending_d;
    logic                   proto_err_q, proto_err_d;
    logic [TAG_WIDTH-1:0]   issued_tag_q, issued_tag_d;
    cnt_t                   hit_cnt_q, hit_cnt_d;
    cnt_t                   miss_cnt_q, miss_cnt_d;

    logic [RQ_ADDR_WIDTH:0] credits_used;
    logic                   issue;
    logic                   resp_arrive;
    logic                   capture;
    logic                   q_empty;
    logic [RW-1:0]          push_entry;
    logic [RW-1:0]          head_entry;

    // Handshakes are strict valid/ready: a transfer happens on a cycle where
    // both are high; valid never waits on ready, ready may depend on valid-free state only.
    assign credits_used = rq_count + {{RQ_ADDR_WIDTH{1'b0}}, inflight_q};
    assign req_ready    = rst_n && !flush && (credits_used < DEPTH_C) &&
                          !(GATE_ON_EMPTY && cf_empty);
    assign issue        = req_valid && req_ready;
    assign cf_rd_en     = issue;
    assign cf_rd_tag    = issue ? req_tag : '0;

    assign resp_arrive  = cf_rd_valid && inflight_q;
    assign capture      = resp_arrive && !drop_pending_q;
    assign push_entry   = {cf_rd_hit, issued_tag_q, cf_rd_data};

    always_comb begin
        inflight_d     = inflight_q;
        drop_pending_d = drop_pending_q;
        proto_err_d    = proto_err_q;
        issued_tag_d   = issued_tag_q;
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;

        if (issue) begin
            inflight_d   = 1'b1;
            issued_tag_d = req_tag;
        end else if (cf_rd_valid) begin
            inflight_d   = 1'b0;
        end

        if (resp_arrive) begin
            if (cf_rd_hit) hit_cnt_d  = sat_inc(hit_cnt_q);
            else           miss_cnt_d = sat_inc(miss_cnt_q);
        end

        if (cf_rd_valid && !inflight_q) proto_err_d = 1'b1;

        // A response landing in the flush cycle is already killed by the queue
        // flush; only one still outstanding afterwards needs dropping later.
        if (flush && inflight_q && !cf_rd_valid) drop_pending_d = 1'b1;
        else if (cf_rd_valid)                    drop_pending_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q     <= 1'b0;
            drop_pending_q <= 1'b0;
            proto_err_q    <= 1'b0;
            issued_tag_q   <= '0;
            hit_cnt_q      <= '0;
            miss_cnt_q     <= '0;
        end else begin
            inflight_q     <= inflight_d;
            drop_pending_q <= drop_pending_d;
            proto_err_q    <= proto_err_d;
            issued_tag_q   <= issued_tag_d;
            hit_cnt_q      <= hit_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
        end
    end

    cache_read_adapter_rsp_queue #(
        .WIDTH      (RW),
        .ADDR_WIDTH (RQ_ADDR_WIDTH)
    ) u_rsp_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (capture),
        .push_data_i (push_entry),
        .pop_i       (resp_ready),
        .flush_i     (flush),
        .head_o      (head_entry),
        .count_o     (rq_count),
        .empty_o     (q_empty)
    );

    assign resp_valid = !q_empty;
    assign resp_hit   = head_entry[HIT_BIT];
    assign resp_tag   = head_entry[TAG_LSB +: TAG_WIDTH];
    assign resp_data  = head_entry[RESP_DATA_LSB +: DATA_WIDTH];
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;
    assign proto_err  = proto_err_q;

endmodule
